multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Moore-style control FSM that sequences a shared-ALU, shared-memory multi-cycle MIPS datapath.
//  It replaces the single-cycle opcode decoder. Each instruction takes 3-5 states:
//  IF, ID, EX, MEM, WB.
//  It drives PC, IR, register-file, memory and ALU-mux enables/selects, and counts retired instructions.
// PARAMETERS
//  CNT_W    32   width of retired-instruction counter instr_cnt
// PORTS
//  CLK          in   1      clock; all state updates on rising edge
//  rst          in   1      synchronous, active-high reset
//  op           in   6      IR[31:26], valid from DECODE onward
//  zero         in   1      ALU zero flag
//  mem_rdy      in   1      memory access complete (used only with MC_MEM_WAIT_EN)
//  PCWrite      out  1      unconditional PC load
//  PCWriteCond  out  1      PC load if zero
//  IorD         out  1      memory addr: 0=PC, 1=ALUOut
//  MemRd        out  1      memory read strobe
//  MemWr        out  1      memory write strobe
//  IRWrite      out  1      instruction register load
//  RegDst       out  1      write reg: 0=rt, 1=rd
//  MemtoReg     out  1      write data: 0=ALUOut, 1=MDR
//  RegWr        out  1      register-file write
//  ALUSrcA      out  1      0=PC, 1=rs
//  ALUSrcB      out  2      00=rt, 01=4, 10=sext imm, 11=sext imm<<2
//  ALUOp        out  2      00=add, 01=sub, 10=funct
//  PCSource     out  2      00=ALU, 01=ALUOut, 10=jump target
//  state_o      out  4      current state encoding (debug)
//  instr_done   out  1      1-cycle pulse in final state of every instruction
//  illegal      out  1      1-cycle pulse on unsupported opcode
//  instr_cnt    out  CNT_W  retired-instruction count, wraps at 2^CNT_W
// BEHAVIOUR
//  States (4b): FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXEC=6 ALUWB=7
//  BRANCH=8 JUMP=9 ADDIEX=10 ADDIWB=11 ILLEGAL=12; codes 13-15 -> FETCH next cycle.
//  Transitions:
//   - FETCH -> DECODE.
//   - DECODE on op:
//     - 000000 -> EXEC
//     - 100011 (lw) or 101011 (sw) -> MEMADR
//     - 000100 (beq) -> BRANCH
//     - 000010 (j) -> JUMP
//     - 001000 (addi) -> ADDIEX
//     - else -> ILLEGAL
//   - MEMADR -> MEMRD (lw) or MEMWR (sw).
//   - MEMRD -> MEMWB.
//   - EXEC -> ALUWB.
//   - ADDIEX -> ADDIWB.
//   - MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP, ILLEGAL -> FETCH.
//  Outputs are decoded from state only; every unlisted output is 0.
//   - FETCH:  MemRd=1 IorD=0 IRWrite=1 ALUSrcA=0 ALUSrcB=01 ALUOp=00 PCSource=00 PCWrite=1
//   - DECODE: ALUSrcA=0 ALUSrcB=11 ALUOp=00
//   - MEMADR, ADDIEX: ALUSrcA=1 ALUSrcB=10 ALUOp=00
//   - MEMRD: MemRd=1 IorD=1
//   - MEMWB: RegDst=0 MemtoReg=1 RegWr=1
//   - MEMWR: MemWr=1 IorD=1
//   - EXEC: ALUSrcA=1 ALUSrcB=00 ALUOp=10
//   - ALUWB: RegDst=1 MemtoReg=0 RegWr=1
//   - ADDIWB: RegDst=0 MemtoReg=0 RegWr=1
//   - BRANCH: ALUSrcA=1 ALUSrcB=00 ALUOp=01 PCWriteCond=1 PCSource=01
//   - JUMP: PCWrite=1 PCSource=10
//   - ILLEGAL: illegal=1
//  instr_done is asserted in MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP.
//  instr_cnt increments on that same edge; ILLEGAL does not count.
//  Latency without waits: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.
//  Reset: while rst=1, all write/strobe outputs (PCWrite, PCWriteCond, IRWrite, RegWr, MemRd,
//   MemWr, instr_done, illegal) are forced 0.
//   At the edge, state <= FETCH and instr_cnt <= 0.
//   Reset mid-instruction abandons it: no partial write, no count.
//  Selects (IorD, ALUSrc*, ALUOp, PCSource, RegDst, MemtoReg) are don't-care during reset;
//   drive them to the FETCH values.
// CONFIGURATION
//  MC_MEM_WAIT_EN defined:
//   - FETCH, MEMRD and MEMWR hold while mem_rdy=0, keeping their strobes asserted.
//   - In FETCH, IRWrite and PCWrite are gated by mem_rdy, so they fire exactly once.
//   - MEMWR's instr_done pulse and count wait for mem_rdy.
//   - Each wait cycle adds 1 to latency.
//  MC_MEM_WAIT_EN undefined: mem_rdy is ignored; fixed latencies as above.
// STRUCTURE
//  multicycle_ctrl_pkg (shared `include):
//   - state codes
//   - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
//   - ALUOp, ALUSrcB and PCSource codes
//  Sub-module multicycle_ctrl_dec: combinational state -> control-word decode.
//  The top holds the state register, next-state logic, wait gating and counter.
// TESTING
//  1. rst=1 for 2 cycles with op=100011 -> all strobes 0; after release, state_o=0 and instr_cnt=0.
//  2. op=100011, no waits -> states 0,1,2,3,4; RegWr=1 only in state 4;
//     instr_done at cycle 5; instr_cnt=1.
//  3. op=000100 with zero=1, then zero=0 -> PCWriteCond=1 in state 8 both times;
//     3 cycles each; instr_cnt +2.
//  4. op=111111 -> DECODE->ILLEGAL; illegal pulses once; back to FETCH; instr_cnt unchanged.
//  5. MC_MEM_WAIT_EN, op=101011, mem_rdy=0 for 3 cycles in MEMWR ->
//     MemWr held 4 cycles; instr_done only on the mem_rdy=1 cycle.
//  6. rst asserted during MEMRD -> no RegWr follows; state_o=0 next cycle; instr_cnt=0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared state codes, opcodes, select encodings and control-word layout for multicycle_ctrl.
// Optional memory wait-state handling in the top is enabled by defining MC_MEM_WAIT_EN.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_ILLEGAL = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRd;
        logic       memWr;
        logic       irWrite;
        logic       regDst;
        logic       memtoReg;
        logic       regWr;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSource;
        logic       illegal;
        logic       instrDone;
    } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_dec.sv
// Pure state -> control-word decode for the multicycle controller (Moore outputs).
module multicycle_ctrl_dec
    import multicycle_ctrl_pkg::*;
(
    input  state_t state_i,
    output ctrl_t  ctrl_o
);

    // Every field not named for a state stays at zero.
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.memRd   = 1'b1;
                ctrl_o.irWrite = 1'b1;
                ctrl_o.aluSrcB = SRCB_FOUR;
                ctrl_o.aluOp   = ALUOP_ADD;
                ctrl_o.pcWrite = 1'b1;
            end
            S_DECODE: begin
                ctrl_o.aluSrcB = SRCB_IMMSH;
                ctrl_o.aluOp   = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl_o.aluSrcA = 1'b1;
                ctrl_o.aluSrcB = SRCB_IMM;
                ctrl_o.aluOp   = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl_o.memRd = 1'b1;
                ctrl_o.iorD  = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.memtoReg  = 1'b1;
                ctrl_o.regWr     = 1'b1;
                ctrl_o.instrDone = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.memWr     = 1'b1;
                ctrl_o.iorD      = 1'b1;
                ctrl_o.instrDone = 1'b1;
            end
            S_EXEC: begin
                ctrl_o.aluSrcA = 1'b1;
                ctrl_o.aluSrcB = SRCB_RT;
                ctrl_o.aluOp   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.regDst    = 1'b1;
                ctrl_o.regWr     = 1'b1;
                ctrl_o.instrDone = 1'b1;
            end
            S_ADDIWB: begin
                ctrl_o.regWr     = 1'b1;
                ctrl_o.instrDone = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.aluSrcA     = 1'b1;
                ctrl_o.aluSrcB     = SRCB_RT;
                ctrl_o.aluOp       = ALUOP_SUB;
                ctrl_o.pcWriteCond = 1'b1;
                ctrl_o.pcSource    = PCSRC_ALUOUT;
                ctrl_o.instrDone   = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pcWrite   = 1'b1;
                ctrl_o.pcSource  = PCSRC_JUMP;
                ctrl_o.instrDone = 1'b1;
            end
            S_ILLEGAL: ctrl_o.illegal = 1'b1;
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: state register, next-state logic and retired-instruction counter.
// Define MC_MEM_WAIT_EN to stall FETCH/MEMRD/MEMWR on mem_rdy; otherwise mem_rdy is ignored.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic             zero,
    input  logic             mem_rdy,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRd,
    output logic             MemWr,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWr,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state_o,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t           state_q, state_d, decState;
    ctrl_t            decWord, ctrlWord;
    logic [CNT_W-1:0] cnt_q;
    logic             memReady;

    // The branch decision is taken by the datapath through PCWriteCond, so zero is not consumed here.
`ifdef MC_MEM_WAIT_EN
    logic unusedInputs;
    assign unusedInputs = zero;
    assign memReady     = mem_rdy;
`else
    logic unusedInputs;
    assign unusedInputs = ^{zero, mem_rdy};
    assign memReady     = 1'b1;
`endif

    assign decState = rst ? S_FETCH : state_q;

    multicycle_ctrl_dec uDec (
        .state_i (decState),
        .ctrl_o  (decWord)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = memReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = memReady ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = memReady ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Wait gating keeps one-shot effects (IR/PC load, retirement) for the cycle memory completes.
    always_comb begin
        ctrlWord = decWord;
        if (state_q == S_FETCH && !memReady) begin
            ctrlWord.irWrite = 1'b0;
            ctrlWord.pcWrite = 1'b0;
        end
        if (state_q == S_MEMWR && !memReady) begin
            ctrlWord.instrDone = 1'b0;
        end
        if (rst) begin
            ctrlWord.pcWrite     = 1'b0;
            ctrlWord.pcWriteCond = 1'b0;
            ctrlWord.irWrite     = 1'b0;
            ctrlWord.regWr       = 1'b0;
            ctrlWord.memRd       = 1'b0;
            ctrlWord.memWr       = 1'b0;
            ctrlWord.instrDone   = 1'b0;
            ctrlWord.illegal     = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (ctrlWord.instrDone) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign PCWrite     = ctrlWord.pcWrite;
    assign PCWriteCond = ctrlWord.pcWriteCond;
    assign IorD        = ctrlWord.iorD;
    assign MemRd       = ctrlWord.memRd;
    assign MemWr       = ctrlWord.memWr;
    assign IRWrite     = ctrlWord.irWrite;
    assign RegDst      = ctrlWord.regDst;
    assign MemtoReg    = ctrlWord.memtoReg;
    assign RegWr       = ctrlWord.regWr;
    assign ALUSrcA     = ctrlWord.aluSrcA;
    assign ALUSrcB     = ctrlWord.aluSrcB;
    assign ALUOp       = ctrlWord.aluOp;
    assign PCSource    = ctrlWord.pcSource;
    assign instr_done  = ctrlWord.instrDone;
    assign illegal     = ctrlWord.illegal;
    assign state_o     = state_q;
    assign instr_cnt   = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed cases then random instruction streams.
// When built with MC_MEM_WAIT_EN it also exercises a stalled store.
module tb_multicycle_ctrl;

    typedef int pathT[$];

    logic        CLK = 1'b0;
    logic        rst;
    logic [5:0]  op;
    logic        zero;
    logic        mem_rdy;
    logic        PCWrite, PCWriteCond, IorD, MemRd, MemWr, IRWrite;
    logic        RegDst, MemtoReg, RegWr, ALUSrcA;
    logic [1:0]  ALUSrcB, ALUOp, PCSource;
    logic [3:0]  state_o;
    logic        instr_done, illegal;
    logic [31:0] instr_cnt;
    logic [17:0] ctrlWord;

    int errors = 0;
    int checks = 0;
    int mCnt   = 0;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .CLK         (CLK),
        .rst         (rst),
        .op          (op),
        .zero        (zero),
        .mem_rdy     (mem_rdy),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRd       (MemRd),
        .MemWr       (MemWr),
        .IRWrite     (IRWrite),
        .RegDst      (RegDst),
        .MemtoReg    (MemtoReg),
        .RegWr       (RegWr),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .state_o     (state_o),
        .instr_done  (instr_done),
        .illegal     (illegal),
        .instr_cnt   (instr_cnt)
    );

    always #5 CLK = ~CLK;

    assign ctrlWord = {PCWrite, PCWriteCond, IorD, MemRd, MemWr, IRWrite, RegDst, MemtoReg,
                       RegWr, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal, instr_done};

    // Sequence of visited states for one instruction, straight from the opcode table.
    function automatic pathT pathFor(input logic [5:0] opV);
        pathT p;
        case (opV)
            6'b000000: p = '{0, 1, 6, 7};
            6'b100011: p = '{0, 1, 2, 3, 4};
            6'b101011: p = '{0, 1, 2, 5};
            6'b000100: p = '{0, 1, 8};
            6'b000010: p = '{0, 1, 9};
            6'b001000: p = '{0, 1, 10, 11};
            default:   p = '{0, 1, 12};
        endcase
        return p;
    endfunction

    function automatic bit retires(input int s);
        return (s == 4) || (s == 5) || (s == 7) || (s == 8) || (s == 9) || (s == 11);
    endfunction

    // Control outputs listed per state; anything not named is zero.
    function automatic logic [17:0] expWord(input int s);
        logic pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rwr, srca, ill, done;
        logic [1:0] srcb, aluop, pcsrc;
        {pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rwr, srca, ill, done} = '0;
        {srcb, aluop, pcsrc} = '0;
        case (s)
            0:  begin mrd = 1; irw = 1; srcb = 2'b01; pcw = 1; end
            1:  srcb = 2'b11;
            2, 10: begin srca = 1; srcb = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin m2r = 1; rwr = 1; done = 1; end
            5:  begin mwr = 1; iord = 1; done = 1; end
            6:  begin srca = 1; aluop = 2'b10; end
            7:  begin rdst = 1; rwr = 1; done = 1; end
            8:  begin srca = 1; aluop = 2'b01; pcwc = 1; pcsrc = 2'b01; done = 1; end
            9:  begin pcw = 1; pcsrc = 2'b10; done = 1; end
            11: begin rwr = 1; done = 1; end
            12: ill = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rwr, srca, srcb, aluop, pcsrc, ill, done};
    endfunction

    function automatic logic [17:0] resetWord();
        return {10'b0, 2'b01, 2'b00, 2'b00, 2'b00};
    endfunction

    task automatic applyStimulus(input logic [5:0] opV, input logic zV);
        op   = opV;
        zero = zV;
`ifdef MC_MEM_WAIT_EN
        mem_rdy = 1'b1;
`else
        mem_rdy = 1'($urandom_range(0, 1));
`endif
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Walks one instruction from FETCH; abortAt >= 0 asserts reset while in that path step.
    task automatic runInstr(input logic [5:0] opV, input logic zV, input int abortAt);
        pathT path;
        path = pathFor(opV);
        foreach (path[i]) begin
            applyStimulus(opV, zV);
            if (i == abortAt) begin
                rst = 1'b1;
                #1;
                checkOutput("abort_ctrl", 64'(ctrlWord), 64'(resetWord()));
                @(negedge CLK);
                rst = 1'b0;
                #1;
                mCnt = 0;
                checkOutput("abort_state", 64'(state_o), 64'd0);
                checkOutput("abort_cnt", 64'(instr_cnt), 64'(mCnt));
                return;
            end
            #1;
            checkOutput("state", 64'(state_o), 64'(path[i]));
            checkOutput("ctrl", 64'(ctrlWord), 64'(expWord(path[i])));
            checkOutput("cnt", 64'(instr_cnt), 64'(mCnt));
            @(negedge CLK);
        end
        if (retires(path[path.size()-1])) mCnt++;
    endtask

    initial begin
        logic [5:0] legalOps [6];
        legalOps = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};

        rst = 1'b1;
        applyStimulus(6'b100011, 1'b0);
        @(negedge CLK);
        #1 checkOutput("reset_ctrl0", 64'(ctrlWord), 64'(resetWord()));
        @(negedge CLK);
        #1 checkOutput("reset_ctrl1", 64'(ctrlWord), 64'(resetWord()));
        rst = 1'b0;
        #1;
        checkOutput("reset_state", 64'(state_o), 64'd0);
        checkOutput("reset_cnt", 64'(instr_cnt), 64'd0);

        runInstr(6'b100011, 1'b0, -1);
        runInstr(6'b000100, 1'b1, -1);
        runInstr(6'b000100, 1'b0, -1);
        runInstr(6'b111111, 1'b0, -1);
        runInstr(6'b000000, 1'b0, -1);
        runInstr(6'b001000, 1'b0, -1);
        runInstr(6'b000010, 1'b0, -1);
        runInstr(6'b101011, 1'b0, -1);
        #1 checkOutput("cnt_after_directed", 64'(instr_cnt), 64'(mCnt));

`ifdef MC_MEM_WAIT_EN
        begin
            int sw[4];
            sw = '{0, 1, 2, 5};
            for (int i = 0; i < 3; i++) begin
                applyStimulus(6'b101011, 1'b0);
                #1 checkOutput("wait_state", 64'(state_o), 64'(sw[i]));
                @(negedge CLK);
            end
            for (int k = 0; k < 3; k++) begin
                applyStimulus(6'b101011, 1'b0);
                mem_rdy = 1'b0;
                #1;
                checkOutput("wait_hold_state", 64'(state_o), 64'd5);
                checkOutput("wait_hold_ctrl", 64'(ctrlWord), 64'(expWord(5) & ~18'd1));
                @(negedge CLK);
            end
            applyStimulus(6'b101011, 1'b0);
            #1;
            checkOutput("wait_done_ctrl", 64'(ctrlWord), 64'(expWord(5)));
            checkOutput("wait_done_cnt", 64'(instr_cnt), 64'(mCnt));
            @(negedge CLK);
            mCnt++;
        end
`endif

        runInstr(6'b100011, 1'b0, 3);
        runInstr(6'b100011, 1'b0, -1);

        for (int n = 0; n < 40; n++) begin
            int pick;
            logic [5:0] opR;
            pick = $urandom_range(0, 7);
            opR  = (pick < 6) ? legalOps[pick] : 6'($urandom_range(0, 63));
            runInstr(opR, 1'($urandom_range(0, 1)), -1);
        end
        #1 checkOutput("cnt_final", 64'(instr_cnt), 64'(mCnt));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
